// File: rtl/eu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : eu_sequencer_if
// Brief    : Control/data bus between the sequencer (master) and the eu (slave).
// Revision : 1.0
// ============================================================================
interface eu_sequencer_if;
    logic [3:0] eu_opcode;
    logic [3:0] eu_A;
    logic [3:0] eu_B;
    logic [3:0] eu_C;
    logic [3:0] eu_address;
    logic [1:0] eu_En;
    logic       eu_readEnable;
    logic       eu_writeEnable;
    logic [7:0] eu_dataCopy;
    logic [7:0] eu_data;

    modport master (
        output eu_opcode, eu_A, eu_B, eu_C, eu_address, eu_En,
               eu_readEnable, eu_writeEnable, eu_dataCopy,
        input  eu_data
    );

    modport slave (
        input  eu_opcode, eu_A, eu_B, eu_C, eu_address, eu_En,
               eu_readEnable, eu_writeEnable, eu_dataCopy,
        output eu_data
    );
endinterface
`default_nettype wire

// File: rtl/eu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : eu_sequencer
// Brief    : Fetches 16-bit ROM instructions, decodes them and drives the eu.
// Revision : 1.0
// ============================================================================
module eu_sequencer #(
    parameter int PC_W       = 8,
    parameter int ALU_CYCLES = 2,
    parameter int REGS       = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] instr_addr,
    input  logic [15:0]     instr_data,
    eu_sequencer_if.master  eu,
    output logic [7:0]      rd_data,
    output logic            rd_valid,
    output logic            busy,
    output logic            halted,
    output logic            err
);
    localparam int               CNT_W      = (ALU_CYCLES > 1) ? $clog2(ALU_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ALU_CYCLES - 1);
    localparam logic [4:0]       c_regs     = 5'(REGS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_CAPT   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [3:0]       c_q, c_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       dcopy_q, dcopy_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;

    logic [3:0] w_op, w_fa, w_fb, w_fc;
    logic [7:0] w_imm;
    logic       w_bad_a, w_bad_alu;

    assign w_op  = ir_q[15:12];
    assign w_fa  = ir_q[11:8];
    assign w_fb  = ir_q[7:4];
    assign w_fc  = ir_q[3:0];
    assign w_imm = ir_q[7:0];

    assign w_bad_a   = ({1'b0, w_fa} >= c_regs);
    assign w_bad_alu = w_bad_a || ({1'b0, w_fb} >= c_regs) || ({1'b0, w_fc} >= c_regs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            cnt_q      <= '0;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            addr_q     <= '0;
            dcopy_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            opcode_q   <= opcode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            addr_q     <= addr_d;
            dcopy_q    <= dcopy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        opcode_d   = opcode_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        addr_d     = addr_q;
        dcopy_d    = dcopy_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        halted_d   = halted_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    halted_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = instr_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Illegal-register instructions fall through to FETCH untouched.
                state_d = S_FETCH;
                if (w_op <= 4'hB) begin
                    if (w_bad_alu) begin
                        err_d = 1'b1;
                    end else begin
                        opcode_d = w_op;
                        a_d      = w_fa;
                        b_d      = w_fb;
                        c_d      = w_fc;
                        cnt_d    = '0;
                        state_d  = S_EXEC;
                    end
                end else if (w_op == 4'hC || w_op == 4'hD) begin
                    if (w_bad_a) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = w_fa;
                        if (w_op == 4'hC) begin
                            dcopy_d = w_imm;
                        end
                        state_d = S_MEM;
                    end
                end else if (w_op == 4'hE) begin
                    pc_d = PC_W'(w_imm);
                end else begin
                    busy_d   = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_EXEC: begin
                if (cnt_q == c_cnt_last) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MEM: state_d = (w_op == 4'hD) ? S_CAPT : S_FETCH;
            S_CAPT: begin
                // rd_valid is registered so its pulse lines up with the new rd_data.
                rd_data_d  = eu.eu_data;
                rd_valid_d = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Mode/enable outputs decode straight from state so reset idles the eu at once.
    assign eu.eu_En          = (state_q == S_EXEC) ? 2'b00 :
                               (state_q == S_MEM)  ? 2'b01 : 2'b11;
    assign eu.eu_writeEnable = (state_q == S_MEM) && (w_op == 4'hC);
    assign eu.eu_readEnable  = (state_q == S_MEM) && (w_op == 4'hD);
    assign eu.eu_opcode      = opcode_q;
    assign eu.eu_A           = a_q;
    assign eu.eu_B           = b_q;
    assign eu.eu_C           = c_q;
    assign eu.eu_address     = addr_q;
    assign eu.eu_dataCopy    = dcopy_q;

    assign instr_addr = pc_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign err        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_eu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eu_sequencer
// Brief    : Directed + random-program bench against a program-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_eu_sequencer;
    localparam int PC_W       = 8;
    localparam int ALU_CYCLES = 2;
    localparam int REGS       = 6;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] instr_addr;
    logic [15:0]     instr_data = '0;
    logic [7:0]      rd_data;
    logic            rd_valid, busy, halted, err;

    eu_sequencer_if eu_bus();

    eu_sequencer #(.PC_W(PC_W), .ALU_CYCLES(ALU_CYCLES), .REGS(REGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .instr_addr(instr_addr),
        .instr_data(instr_data),
        .eu        (eu_bus),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM and a simple eu register file.
    logic [15:0] rom [256];
    logic [7:0]  eu_mem [16] = '{default: 8'h00};
    logic [7:0]  eu_data_r = '0;
    assign eu_bus.eu_data = eu_data_r;

    always @(posedge clk) begin
        instr_data <= rom[instr_addr];
        if (eu_bus.eu_En == 2'b01 && eu_bus.eu_writeEnable)
            eu_mem[eu_bus.eu_address] <= eu_bus.eu_dataCopy;
        if (eu_bus.eu_En == 2'b01 && eu_bus.eu_readEnable)
            eu_data_r <= eu_mem[eu_bus.eu_address];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int ref_mem [16] = '{default: 0};
    int exp_alu[$], exp_wr[$], exp_rd[$];
    int obs_alu[$], obs_wr[$], obs_rd[$], obs_pc[$];
    int viol, alu_len, alu_ops, last_cycles;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level interpreter: what each program should do and how long it takes.
    task automatic model_run(output int cyc, output bit e);
        int pc, guard, op, a, b, c, imm;
        bit done;
        logic [15:0] w;
        exp_alu.delete(); exp_wr.delete(); exp_rd.delete();
        pc = 0; cyc = 1; e = 0; done = 0; guard = 0;
        while (!done && guard < 500) begin
            w = rom[pc];
            pc = (pc + 1) % (1 << PC_W);
            guard++;
            op = int'(w[15:12]); a = int'(w[11:8]); b = int'(w[7:4]);
            c = int'(w[3:0]); imm = int'(w[7:0]);
            if (op <= 11) begin
                if (a >= REGS || b >= REGS || c >= REGS) begin e = 1; cyc += 3; end
                else begin
                    exp_alu.push_back((op << 20) | (a << 16) | (b << 12) | (c << 8) | ALU_CYCLES);
                    cyc += 3 + ALU_CYCLES;
                end
            end else if (op == 12 || op == 13) begin
                if (a >= REGS) begin e = 1; cyc += 3; end
                else if (op == 12) begin
                    ref_mem[a] = imm;
                    exp_wr.push_back((a << 8) | imm);
                    cyc += 4;
                end else begin
                    exp_rd.push_back(ref_mem[a]);
                    cyc += 5;
                end
            end else if (op == 14) begin
                pc = imm % (1 << PC_W);
                cyc += 3;
            end else begin
                cyc += 3;
                done = 1;
            end
        end
    endtask

    task automatic observe();
        int cur;
        if (eu_bus.eu_readEnable && eu_bus.eu_writeEnable) viol++;
        if ((eu_bus.eu_readEnable || eu_bus.eu_writeEnable) && eu_bus.eu_En != 2'b01) viol++;
        if (!halted && !busy) viol++;
        if (eu_bus.eu_En == 2'b00) begin
            cur = int'({eu_bus.eu_opcode, eu_bus.eu_A, eu_bus.eu_B, eu_bus.eu_C});
            if (alu_len == 0) alu_ops = cur;
            else if (cur != alu_ops) viol++;
            alu_len++;
        end else if (alu_len > 0) begin
            obs_alu.push_back((alu_ops << 8) | alu_len);
            alu_len = 0;
        end
        if (eu_bus.eu_writeEnable)
            obs_wr.push_back(int'({eu_bus.eu_address, eu_bus.eu_dataCopy}));
        if (rd_valid) obs_rd.push_back(int'(rd_data));
        if (obs_pc.size() == 0 || int'(instr_addr) != obs_pc[$]) obs_pc.push_back(int'(instr_addr));
    endtask

    // Runs the program in rom from pc=0 to HALT; optionally pulses start mid-run.
    task automatic run_prog(input string tag, input bit poke);
        int exp_cyc, n;
        bit exp_err;
        model_run(exp_cyc, exp_err);
        obs_alu.delete(); obs_wr.delete(); obs_rd.delete(); obs_pc.delete();
        viol = 0; alu_len = 0; alu_ops = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        observe();
        while (!halted && n < 700) begin
            start = (poke && n == 3);
            @(negedge clk);
            n++;
            observe();
        end
        start = 1'b0;
        last_cycles = n;
        check({tag, ".cycles"}, n, exp_cyc);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".busy_at_halt"}, busy, 0);
        check({tag, ".invariants"}, viol, 0);
        check({tag, ".n_alu"}, obs_alu.size(), exp_alu.size());
        check({tag, ".n_wr"}, obs_wr.size(), exp_wr.size());
        check({tag, ".n_rd"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++)
            check({tag, ".alu"}, obs_alu[i], exp_alu[i]);
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check({tag, ".wr"}, obs_wr[i], exp_wr[i]);
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            check({tag, ".rd"}, obs_rd[i], exp_rd[i]);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(REGS, 15));
        return 4'($urandom_range(0, REGS - 1));
    endfunction

    task automatic gen_prog(input int len);
        int k, t;
        logic [3:0] op, a, b, c;
        clear_rom();
        for (int i = 0; i < len; i++) begin
            k = int'($urandom_range(0, 9));
            a = rand_reg(); b = rand_reg(); c = rand_reg();
            if (k < 5) begin
                op = 4'($urandom_range(0, 11));
                rom[i] = {op, a, b, c};
            end else if (k < 7) rom[i] = {4'hC, a, 8'($urandom)};
            else if (k < 9)     rom[i] = {4'hD, a, 8'h00};
            else begin
                t = int'($urandom_range(i + 1, len));
                rom[i] = {4'hE, 4'h0, 8'(t)};
            end
        end
    endtask

    initial begin
        clear_rom();
        repeat (3) @(negedge clk);
        check("reset.En", eu_bus.eu_En, 2'b11);
        check("reset.rw", {eu_bus.eu_readEnable, eu_bus.eu_writeEnable}, 0);
        check("reset.flags", {busy, halted, err, rd_valid}, 0);
        check("reset.addr", instr_addr, 0);
        check("reset.ops", {eu_bus.eu_opcode, eu_bus.eu_A, eu_bus.eu_B, eu_bus.eu_C,
                            eu_bus.eu_address, eu_bus.eu_dataCopy, rd_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LDI then HALT: single write of 0x5A to reg 2, halted on the 8th clock.
        rom[0] = 16'hC25A; rom[1] = 16'hF000;
        run_prog("ldi", 1'b0);
        check("ldi.halt_clk", last_cycles, 8);
        check("ldi.write", (obs_wr.size() == 1) ? obs_wr[0] : -1, 'h25A);
        check("ldi.halted", halted, 1);

        // ALU op 3 with A=1 B=2 C=4: two En=00 clocks, then fetch from address 1.
        clear_rom(); rom[0] = 16'h3124;
        run_prog("alu", 1'b0);
        check("alu.event", (obs_alu.size() == 1) ? obs_alu[0] : -1, 'h312402);
        check("alu.next_fetch", (obs_pc.size() > 1) ? obs_pc[1] : -1, 1);

        // Load then read back register 3.
        clear_rom(); rom[0] = 16'hC377; rom[1] = 16'hD300;
        run_prog("rd", 1'b0);
        check("rd.value", (obs_rd.size() == 1) ? obs_rd[0] : -1, 'h77);

        // Illegal register 7: err set, no write, program still reaches HALT.
        clear_rom(); rom[0] = 16'hC711;
        run_prog("illegal", 1'b0);
        check("illegal.err", err, 1);
        check("illegal.no_wr", obs_wr.size(), 0);
        clear_rom();
        run_prog("err_clear", 1'b0);
        check("err_clear.err", err, 0);

        // Forward jump to 0x10.
        clear_rom(); rom[0] = 16'hE010;
        run_prog("jmp", 1'b0);
        check("jmp.target", (obs_pc.size() > 2) ? obs_pc[2] : -1, 'h10);

        // Jump to 255, execute an ALU op there, pc must wrap to 0.
        clear_rom(); rom[0] = 16'hE0FF; rom[255] = 16'h0000;
        obs_pc.delete();
        start = 1'b1; @(negedge clk); start = 1'b0;
        obs_pc.push_back(int'(instr_addr));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (int'(instr_addr) != obs_pc[$]) obs_pc.push_back(int'(instr_addr));
        end
        check("wrap.seq", (obs_pc.size() >= 4) ? {obs_pc[0][7:0], obs_pc[1][7:0], obs_pc[2][7:0], obs_pc[3][7:0]} : -1,
              32'h0001FF00);

        // Asynchronous reset in the middle of an ALU instruction.
        clear_rom(); rom[0] = 16'h3124;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && eu_bus.eu_En != 2'b00; i++) @(negedge clk);
        check("rst_mid.in_exec", eu_bus.eu_En, 2'b00);
        rst_n = 1'b0;
        #1;
        check("rst_mid.En", eu_bus.eu_En, 2'b11);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.pc", instr_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid.idle", {busy, halted, eu_bus.eu_En, instr_addr}, {2'b00, 2'b11, 8'h00});

        // Random programs; every third one also gets a start pulse while busy.
        for (int p = 0; p < 30; p++) begin
            gen_prog(int'($urandom_range(4, 14)));
            run_prog($sformatf("rand%0d", p), (p % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/eu_sequencer.md
Name: eu_sequencer

Overview:
Instruction sequencer and initiator for the execution unit (eu). It fetches 16-bit instruction words from a synchronous program ROM and decodes them. It then drives the eu control inputs (opcode, A/B/C, En, address, readEnable, writeEnable, dataCopy) with the required mode timing. It also captures register read-back from the eu data output.

Parameters:
PC_W, 8, program counter / instruction address width
ALU_CYCLES, 2, clocks En is held at 2'b00 per ALU instruction (covers ALU latency plus the eu result write)
REGS, 6, number of eu registers; register indices >= REGS are illegal

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin execution at pc=0; ignored while busy
instr_addr  output  PC_W  program ROM address
instr_data  input  16  ROM word, valid one clock after instr_addr
eu_opcode  output  4  to eu opcode
eu_A, eu_B, eu_C  output  4 each  to eu operand/destination register indices
eu_address  output  4  to eu address
eu_En  output  2  to eu En: 2'b00 ALU mode, 2'b01 memory mode, 2'b11 idle
eu_readEnable  output  1  to eu readEnable
eu_writeEnable  output  1  to eu writeEnable
eu_dataCopy  output  8  to eu dataCopy (immediate write data)
eu_data  input  8  from eu data
rd_data  output  8  captured read-back value
rd_valid  output  1  one-cycle pulse when rd_data is updated
busy  output  1  high from the start pulse until the HALT state
halted  output  1  high in HALT
err  output  1  sticky illegal-register flag, cleared by start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, eu_En=2'b11, eu_readEnable=eu_writeEnable=0, all other outputs 0, busy=halted=err=rd_valid=0.
- Instruction format: [15:12] op, [11:8] A/reg, [7:4] B, [3:0] C, imm=[7:0].
- Opcode classes:
  - op 0x0-0xB: ALU operation, passed to eu_opcode.
  - 0xC: LDI, M[reg] <= imm.
  - 0xD: RD, read M[reg].
  - 0xE: JMP, pc <= imm[PC_W-1:0].
  - 0xF: HALT.
- FSM states: IDLE, FETCH, LATCH, DECODE, EXEC, MEM, CAPT, HALT.
- IDLE/HALT -> FETCH on start. On start: pc<=0, err<=0, busy<=1.
- FETCH (1 clk): instr_addr=pc.
- LATCH (1 clk): ir<=instr_data; pc<=pc+1, wrapping 2^PC_W-1 -> 0.
- DECODE (1 clk), branch on op:
  - ALU: eu_opcode/A/B/C <= ir fields, then EXEC.
  - LDI: eu_address<=reg, eu_dataCopy<=imm, then MEM.
  - RD: eu_address<=reg, then MEM.
  - JMP: pc<=imm, then FETCH.
  - HALT: busy<=0, halted<=1, then HALT.
- Illegal register: any referenced index >= REGS sets err. The instruction is skipped (return to FETCH) with no eu activity. Referenced indices: A, B and C for ALU ops; reg for LDI/RD.
- EXEC: eu_En=2'b00 for exactly ALU_CYCLES clocks, read/write enables low, opcode/A/B/C held stable, then eu_En=2'b11 and FETCH. ALU instruction total = 3+ALU_CYCLES clocks.
- MEM (1 clk): eu_En=2'b01.
  - LDI: eu_writeEnable=1, then FETCH.
  - RD: eu_readEnable=1, then CAPT.
  - readEnable and writeEnable are never high together.
- CAPT (1 clk): eu_En=2'b11; rd_data<=eu_data; rd_valid=1 for this clock only; then FETCH.
- Outside EXEC/MEM: eu_En=2'b11 and both enables 0. The eu therefore never sees En=2'b00 with stale operands.
- start while busy: ignored.
- rst_n asserted mid-instruction: immediate idle outputs; no partial eu write completes after reset assertion.

Test Plan:
- Reset: rst_n=0 mid-EXEC -> same cycle eu_En=2'b11, busy=0, pc=0; after release, IDLE until start.
- LDI: ROM[0]=0xC2_5A, ROM[1]=0xF000, start -> one clock with eu_En=01, eu_writeEnable=1, eu_address=2, eu_dataCopy=0x5A; halted=1 after 8 clocks.
- ALU: ROM[0]=0x3124 (op3, A=1, B=2, C=4) -> eu_En=00 for exactly 2 clocks with opcode=3/A=1/B=2/C=4 stable; next fetch at instr_addr=1.
- RD: ROM[0]=0xD300, eu_data model returns 0x77 -> eu_readEnable one clock; next clock rd_data=0x77 with a single-cycle rd_valid pulse.
- JMP/wrap: PC_W=8, ROM[255]=0x0000 ALU op, ROM[0]=0xF000 -> after 255, instr_addr=0. ROM[0]=0xE010 -> next instr_addr=0x10.
- Illegal: ROM[0]=0xC7_11 (reg 7 >= 6) -> err=1, no eu_writeEnable, execution continues; start clears err.
